// File: rtl/mux_arb_n_pkg.sv
// Shared constants and helpers for the N-channel registered mux/arbiter.
// Mode encodings are reused by the control unit.
package mux_arb_n_pkg;

    localparam logic MUX_MODE_FIXED = 1'b0;
    localparam logic MUX_MODE_RR    = 1'b1;

    // Channel-index width: at least one bit even for N == 2.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// Handshake bundle between N producers, the mux/arbiter and one consumer.
// The slave modport is the arbiter's view; master is the environment's.
interface mux_arb_n_if
    import mux_arb_n_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32
);

    localparam int SELW = sel_width(N);

    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// Rotating-priority picker: first set req bit at or after ptr, wrapping.
// Purely combinational; ptr is assumed to be below N.
module rr_pick
    import mux_arb_n_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_idx = '0;
        any     = |req;
        idx     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (req[idx]) gnt_idx = SELW'(idx);
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel registered mux with fixed-select and round-robin modes.
// Single-entry output register gives one-cycle latency at full rate.
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    mux_arb_n_if.slave  bus
);

    localparam int SELW = sel_width(N);
    localparam int PADW = 1 << SELW;

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  pick_idx;
    logic [SELW-1:0]  grant;
    logic             pick_any;
    logic             any;
    logic             free;
    logic             xfer;
    logic [PADW-1:0]  valid_pad;
    logic [N-1:0]     ready;

    logic             q_valid;
    logic [WIDTH-1:0] q_data;
    logic [SELW-1:0]  q_chan;

    // Zero padding makes any sel >= N see an idle channel.
    assign valid_pad = PADW'(bus.in_valid);

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req     (bus.in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        free = !q_valid || bus.out_ready;
        if (bus.mode == MUX_MODE_RR) begin
            grant = pick_idx;
            any   = pick_any;
        end else begin
            grant = bus.sel;
            any   = valid_pad[bus.sel];
        end
        xfer  = free && any;
        ready = xfer ? (N'(1) << grant) : '0;
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = q_valid;
    assign bus.out_data  = q_data;
    assign bus.out_chan  = q_chan;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_chan  <= '0;
            rr_ptr  <= '0;
        end else if (free) begin
            q_valid <= xfer;
            if (xfer) begin
                q_data <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
                q_chan <= grant;
                if (bus.mode == MUX_MODE_RR) begin
                    rr_ptr <= (grant == SELW'(N - 1)) ? '0
                                                      : grant + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n at N=4, N=6 and N=3.
// Expected outputs are queued when stimulus is driven.
module tb_mux_arb_n;
    import mux_arb_n_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  chan;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t e;
    logic [31:0] d4 [4];

    always #5 clk = ~clk;

    mux_arb_n_if #(.N(4), .WIDTH(32)) a4 ();
    mux_arb_n_if #(.N(6), .WIDTH(32)) a6 ();
    mux_arb_n_if #(.N(3), .WIDTH(32)) a3 ();

    mux_arb_n #(.N(4), .WIDTH(32)) u4 (
        .clk(clk), .reset(rst_n), .bus(a4.slave));
    mux_arb_n #(.N(6), .WIDTH(32)) u6 (
        .clk(clk), .reset(rst_n), .bus(a6.slave));
    mux_arb_n #(.N(3), .WIDTH(32)) u3 (
        .clk(clk), .reset(rst_n), .bus(a3.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic load4;
        a4.in_data = {d4[3], d4[2], d4[1], d4[0]};
    endtask

    task automatic idle_all;
        a4.mode = MUX_MODE_FIXED; a4.sel = '0;
        a4.in_valid = '0; a4.out_ready = 1'b1;
        a6.mode = MUX_MODE_FIXED; a6.sel = '0;
        a6.in_valid = '0; a6.out_ready = 1'b1;
        a3.mode = MUX_MODE_FIXED; a3.sel = '0;
        a3.in_valid = '0; a3.out_ready = 1'b1;
        d4[0] = 32'hC0C0_0000; d4[1] = 32'h0000_1111;
        d4[2] = 32'h0000_2222; d4[3] = 32'h0000_3333;
        load4();
        for (int k = 0; k < 6; k++)
            a6.in_data[k*32 +: 32] = 32'h6000_0000 + k;
        for (int k = 0; k < 3; k++)
            a3.in_data[k*32 +: 32] = 32'h3000_0000 + k;
    endtask

    task automatic apply_reset;
        idle_all();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        idle_all();
        rst_n = 1'b0;
        settle();
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data, u4.rr_ptr}
            !== {1'b0, 2'd0, 32'd0, 2'd0}) begin
            fails++;
            $display("FAIL reset_init got v=%b c=%0d d=%h want 0,0,0",
                     a4.out_valid, a4.out_chan, a4.out_data);
        end
        tick();
        rst_n = 1'b1;
        d4[0] = 32'h0000_DEAD; load4();
        a4.in_valid = 4'b0001; a4.out_ready = 1'b0;
        tick();
        a4.in_valid = 4'b0000;
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data}
            !== {1'b1, 2'd0, 32'h0000_DEAD}) begin
            fails++;
            $display("FAIL reset_preload got v=%b d=%h want 1 dead",
                     a4.out_valid, a4.out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data}
            !== {1'b0, 2'd0, 32'd0}) begin
            fails++;
            $display("FAIL reset_async got v=%b c=%0d d=%h want 0,0,0",
                     a4.out_valid, a4.out_chan, a4.out_data);
        end
        #1 rst_n = 1'b1;
        tick();
        d4[0] = 32'hC0C0_0000; load4();
        a4.mode = MUX_MODE_RR; a4.in_valid = 4'b1111;
        a4.out_ready = 1'b1;
        settle();
        checks++;
        if (a4.in_ready !== 4'b0001) begin
            fails++;
            $display("FAIL reset_rr_first got %b want 0001", a4.in_ready);
        end
        sb.push_back('{data: d4[0], chan: 3'd0});
        tick();
        e = sb.pop_front();
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data}
            !== {1'b1, e.chan[1:0], e.data}) begin
            fails++;
            $display("FAIL reset_rr_out got c=%0d d=%h want c=%0d d=%h",
                     a4.out_chan, a4.out_data, e.chan, e.data);
        end
    endtask

    task automatic test_fixed;
        apply_reset();
        a4.mode = MUX_MODE_FIXED; a4.sel = 2'd2;
        a4.in_valid = 4'b1111;
        settle();
        checks++;
        if (a4.in_ready !== 4'b0100) begin
            fails++;
            $display("FAIL fixed_ready2 got %b want 0100", a4.in_ready);
        end
        sb.push_back('{data: 32'h0000_2222, chan: 3'd2});
        tick();
        a4.sel = 2'd1; a4.in_valid = 4'b0010;
        settle();
        e = sb.pop_front();
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data}
            !== {1'b1, e.chan[1:0], e.data}) begin
            fails++;
            $display("FAIL fixed_out2 got c=%0d d=%h want c=%0d d=%h",
                     a4.out_chan, a4.out_data, e.chan, e.data);
        end
        checks++;
        if (a4.in_ready !== 4'b0010) begin
            fails++;
            $display("FAIL fixed_ready1 got %b want 0010", a4.in_ready);
        end
        sb.push_back('{data: 32'h0000_1111, chan: 3'd1});
        tick();
        a4.in_valid = 4'b1101;
        settle();
        e = sb.pop_front();
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data}
            !== {1'b1, e.chan[1:0], e.data}) begin
            fails++;
            $display("FAIL fixed_out1 got c=%0d d=%h want c=%0d d=%h",
                     a4.out_chan, a4.out_data, e.chan, e.data);
        end
        checks++;
        if (a4.in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL fixed_others got %b want 0000", a4.in_ready);
        end
        tick();
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data, u4.rr_ptr}
            !== {1'b0, 2'd1, 32'h0000_1111, 2'd0}) begin
            fails++;
            $display("FAIL fixed_bubble got v=%b c=%0d d=%h p=%0d",
                     a4.out_valid, a4.out_chan, a4.out_data, u4.rr_ptr);
        end
    endtask

    task automatic test_fixed_oob;
        apply_reset();
        a6.mode = MUX_MODE_FIXED; a6.sel = 3'd0;
        a6.in_valid = 6'b011111;
        tick();
        a6.sel = 3'd5;
        settle();
        checks++;
        if ({a6.out_valid, a6.out_chan, a6.in_ready}
            !== {1'b1, 3'd0, 6'b000000}) begin
            fails++;
            $display("FAIL oob_sel5_idle got v=%b r=%b want 1 000000",
                     a6.out_valid, a6.in_ready);
        end
        tick();
        checks++;
        if (a6.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL oob_drop got %b want 0", a6.out_valid);
        end
        a6.in_valid = 6'b100000;
        settle();
        checks++;
        if (a6.in_ready !== 6'b100000) begin
            fails++;
            $display("FAIL oob_sel5_last got %b want 100000", a6.in_ready);
        end
        a6.in_valid = 6'b111111;
        for (int s = 6; s < 8; s++) begin
            a6.sel = 3'(s);
            settle();
            checks++;
            if (a6.in_ready !== 6'b000000) begin
                fails++;
                $display("FAIL oob_sel%0d got %b want 000000",
                         s, a6.in_ready);
            end
        end
        a6.in_valid = '0;
    endtask

    task automatic test_rr_fair;
        int seq_a [6];
        int seq_b [4];
        seq_a = '{0, 1, 2, 3, 0, 1};
        seq_b = '{3, 1, 3, 1};
        apply_reset();
        a4.mode = MUX_MODE_RR; a4.in_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            int c;
            c = (i < 6) ? seq_a[i] : seq_b[i-6];
            if (i == 6) a4.in_valid = 4'b1010;
            settle();
            checks++;
            if (a4.in_ready !== 4'(1 << c)) begin
                fails++;
                $display("FAIL rr_ready step%0d got %b want ch%0d",
                         i, a4.in_ready, c);
            end
            sb.push_back('{data: d4[c], chan: 3'(c)});
            tick();
            e = sb.pop_front();
            checks++;
            if ({a4.out_valid, a4.out_chan, a4.out_data}
                !== {1'b1, e.chan[1:0], e.data}) begin
                fails++;
                $display("FAIL rr_out step%0d got v=%b c=%0d want c=%0d",
                         i, a4.out_valid, a4.out_chan, e.chan);
            end
        end
    endtask

    task automatic test_backpressure;
        apply_reset();
        d4[0] = 32'hA5A5_A5A5; load4();
        a4.mode = MUX_MODE_FIXED; a4.sel = 2'd0;
        a4.in_valid = 4'b0001; a4.out_ready = 1'b0;
        tick();
        a4.sel = 2'd1; a4.in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if ({a4.out_valid, a4.out_chan, a4.out_data, a4.in_ready}
                !== {1'b1, 2'd0, 32'hA5A5_A5A5, 4'b0000}) begin
                fails++;
                $display("FAIL bp_hold cyc%0d got c=%0d d=%h r=%b",
                         i, a4.out_chan, a4.out_data, a4.in_ready);
            end
            tick();
        end
        a4.out_ready = 1'b1;
        settle();
        checks++;
        if (a4.in_ready !== 4'b0010) begin
            fails++;
            $display("FAIL bp_release got %b want 0010", a4.in_ready);
        end
        sb.push_back('{data: d4[1], chan: 3'd1});
        tick();
        a4.in_valid = '0;
        e = sb.pop_front();
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data}
            !== {1'b1, e.chan[1:0], e.data}) begin
            fails++;
            $display("FAIL bp_out got c=%0d d=%h want c=%0d d=%h",
                     a4.out_chan, a4.out_data, e.chan, e.data);
        end
        d4[0] = 32'hC0C0_0000; load4();
    endtask

    task automatic test_nonpow2;
        apply_reset();
        a3.mode = MUX_MODE_RR; a3.in_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            int c;
            c = i % 3;
            settle();
            sb.push_back('{data: 32'h3000_0000 + c, chan: 3'(c)});
            tick();
            e = sb.pop_front();
            checks++;
            if ({a3.out_valid, a3.out_chan, a3.out_data, u3.rr_ptr}
                !== {1'b1, e.chan[1:0], e.data,
                     2'((c == 2) ? 0 : c + 1)}) begin
                fails++;
                $display("FAIL wrap step%0d got c=%0d p=%0d want c=%0d",
                         i, a3.out_chan, u3.rr_ptr, e.chan);
            end
        end
        a3.in_valid = '0;
    endtask

    task automatic test_mode_switch;
        apply_reset();
        a4.mode = MUX_MODE_RR; a4.in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        a4.out_ready = 1'b0;
        a4.mode = MUX_MODE_FIXED; a4.sel = 2'd0;
        settle();
        checks++;
        if (a4.in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL ms_stall_ready got %b want 0000", a4.in_ready);
        end
        tick();
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data, u4.rr_ptr}
            !== {1'b1, 2'd2, d4[2], 2'd3}) begin
            fails++;
            $display("FAIL ms_hold got c=%0d d=%h p=%0d want 2 2222 3",
                     a4.out_chan, a4.out_data, u4.rr_ptr);
        end
        a4.out_ready = 1'b1;
        settle();
        checks++;
        if (a4.in_ready !== 4'b0001) begin
            fails++;
            $display("FAIL ms_fixed got %b want 0001", a4.in_ready);
        end
        sb.push_back('{data: d4[0], chan: 3'd0});
        tick();
        a4.mode = MUX_MODE_RR;
        settle();
        e = sb.pop_front();
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data}
            !== {1'b1, e.chan[1:0], e.data}) begin
            fails++;
            $display("FAIL ms_fixed_out got c=%0d want c=%0d",
                     a4.out_chan, e.chan);
        end
        checks++;
        if (a4.in_ready !== 4'b1000) begin
            fails++;
            $display("FAIL ms_rr_resume got %b want 1000", a4.in_ready);
        end
        sb.push_back('{data: d4[3], chan: 3'd3});
        tick();
        e = sb.pop_front();
        checks++;
        if ({a4.out_valid, a4.out_chan, a4.out_data}
            !== {1'b1, e.chan[1:0], e.data}) begin
            fails++;
            $display("FAIL ms_rr_out got c=%0d want c=%0d",
                     a4.out_chan, e.chan);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_fixed_oob();
        test_rr_fair();
        test_backpressure();
        test_nonpow2();
        test_mode_switch();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
